// File: rtl/display_scan.sv
// rtl/display_scan.sv - 4-digit multiplexed 7-segment scan driver with frame-boundary value commit.
// Optional leading-zero blanking is enabled by defining LEAD_BLANK_EN.
module display_scan #(
  parameter int PRESCALE = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] value,
  output logic        ready,
  output logic [3:0]  data_out,
  output logic [3:0]  dig_out,
  output logic        frame_tick
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   pending;
  logic          pend_valid;
  logic [15:0]   shadow;

  logic          wrap;
  logic          frame_wrap;
  logic          commit;
  logic          accept;
  logic [1:0]    idx_nx;
  logic [15:0]   shadow_nx;

  // Digit code for the decoder; blank code 4'hF hides leading zeros when enabled.
  function automatic logic [3:0] digit_code(input logic [15:0] v, input logic [1:0] i);
    logic [3:0] nib;
    logic       blank;
    blank = 1'b0;
    case (i)
      2'd0:    nib = v[3:0];
      2'd1:    nib = v[7:4];
      2'd2:    nib = v[11:8];
      default: nib = v[15:12];
    endcase
`ifdef LEAD_BLANK_EN
    case (i)
      2'd1:    blank = (v[15:4] == 12'h000);
      2'd2:    blank = (v[15:8] == 8'h00);
      2'd3:    blank = (v[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
`endif
    return blank ? 4'hF : nib;
  endfunction

  always_comb begin
    wrap       = (cnt == CNT_LAST);
    frame_wrap = wrap && (idx == 2'd3);
    commit     = frame_wrap && pend_valid;
    accept     = load && ready;
    idx_nx     = wrap ? idx + 2'd1 : idx;
    shadow_nx  = commit ? pending : shadow;
  end

  assign ready = ~pend_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= 2'd0;
      pending    <= 16'h0000;
      pend_valid <= 1'b0;
      shadow     <= 16'h0000;
      data_out   <= 4'h0;
      dig_out    <= 4'b1110;
      frame_tick <= 1'b0;
    end else begin
      cnt        <= wrap ? '0 : cnt + 1'b1;
      idx        <= idx_nx;
      shadow     <= shadow_nx;
      frame_tick <= frame_wrap;
      // Commit and accept are exclusive: accept needs pend_valid low, commit needs it high.
      if (commit) begin
        pend_valid <= 1'b0;
      end else if (accept) begin
        pending    <= value;
        pend_valid <= 1'b1;
      end
      data_out   <= digit_code(shadow_nx, idx_nx);
      dig_out    <= ~(4'b0001 << idx_nx);
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// tb/tb_display_scan.sv - Self-checking bench for display_scan (PRESCALE=4), table vectors plus scoreboard.
module tb_display_scan;
  localparam int P = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = 16'h0000;
  logic        ready;
  logic [3:0]  data_out;
  logic [3:0]  dig_out;
  logic        frame_tick;

  display_scan #(.PRESCALE(P)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value),
    .ready(ready), .data_out(data_out), .dig_out(dig_out), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { logic [15:0] value; int offset; bit extra; } vec_t;
  typedef struct { logic [3:0] dig; logic [3:0] data; } exp_t;
  vec_t        vecs[5];
  exp_t        sb[$];
  exp_t        e;
  logic [15:0] shown;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] exp_nibble(input logic [15:0] v, input int n);
    logic [15:0] up;
    up = v >> (4 * n);
`ifdef LEAD_BLANK_EN
    if (n > 0 && up == 16'h0000) return 4'hF;
`endif
    return up[3:0];
  endfunction

  function automatic logic [3:0] exp_dig(input int n);
    logic [3:0] d;
    d = 4'b1111;
    d[n] = 1'b0;
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_scan(input int n, input logic [15:0] v);
    for (int k = 0; k < n; k++) begin
      int ix;
      step();
      ix = (cyc / P) % 4;
      chk("scan_dig", dig_out, exp_dig(ix));
      chk("scan_data", data_out, exp_nibble(v, ix));
      chk("scan_tick", frame_tick, (cyc % (4 * P) == 0) ? 1 : 0);
    end
  endtask

  task automatic wait_slot(input int off);
    int t;
    t = 0;
    while (!(ready && (cyc % (4 * P)) == off) && t < 64) begin
      step();
      t++;
    end
    if (t >= 64) chk("slot_timeout", 1, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int commit;
    int t;

    vecs[0] = '{16'h1234, 6, 1'b1};
    vecs[1] = '{16'h0070, 15, 1'b0};
    vecs[2] = '{16'h0000, 3, 1'b0};
    vecs[3] = '{16'h9A5F, 0, 1'b0};
    vecs[4] = '{16'h0900, 10, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_dig", dig_out, 4'b1110);
    chk("rst_data", data_out, 4'h0);
    chk("rst_ready", ready, 1'b1);
    chk("rst_tick", frame_tick, 1'b0);
    rst = 1'b0;
    shown = 16'h0000;
    check_scan(20, shown);

    foreach (vecs[i]) begin
      wait_slot(vecs[i].offset);
      load = 1'b1;
      value = vecs[i].value;
      step();
      c = cyc;
      load = 1'b0;
      chk("ld_ready_low", ready, 1'b0);
      chk("ld_old_shown", data_out, exp_nibble(shown, (c / P) % 4));
      for (int n = 0; n < 4; n++) begin
        e.dig = exp_dig(n);
        e.data = exp_nibble(vecs[i].value, n);
        sb.push_back(e);
      end
      if (vecs[i].extra) begin
        load = 1'b1;
        value = 16'h9999;
        step();
        step();
        load = 1'b0;
        chk("ign_ready_low", ready, 1'b0);
      end
      commit = (c / (4 * P) + 1) * (4 * P);
      t = 0;
      while (cyc < commit - 1 && t < 64) begin
        step();
        t++;
      end
      if (t >= 64) chk("commit_timeout", 1, 0);
      chk("pre_commit_old", data_out, exp_nibble(shown, 3));
      chk("pre_commit_ready", ready, 1'b0);
      for (int j = 0; j < 4 * P; j++) begin
        step();
        if (j == 0) begin
          chk("commit_ready", ready, 1'b1);
          chk("commit_tick", frame_tick, 1'b1);
        end
        if (j % P == 0) begin
          if (sb.size() == 0) chk("sb_empty", 1, 0);
          else e = sb.pop_front();
          chk("frame_dig", dig_out, e.dig);
        end
        chk("frame_data", data_out, e.data);
      end
      shown = vecs[i].value;
    end

    wait_slot(1);
    load = 1'b1;
    value = 16'h5678;
    step();
    load = 1'b0;
    chk("rst_pend_ready", ready, 1'b0);
    t = 0;
    while ((cyc % (4 * P)) != 9 && t < 64) begin
      step();
      t++;
    end
    if (t >= 64) chk("dig2_timeout", 1, 0);
    chk("pre_rst_dig2", dig_out, 4'b1011);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_dig", dig_out, 4'b1110);
    chk("mid_rst_data", data_out, 4'h0);
    chk("mid_rst_ready", ready, 1'b1);
    chk("mid_rst_tick", frame_tick, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_scan(20, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/display_scan.md
# display_scan

Time-multiplexed scan driver for the 4-digit common-anode 7-segment display. It holds a 4-digit BCD value, selects one digit at a time at a fixed refresh rate, and presents that digit's BCD code and active-low anode select to the downstream BCD-to-segment decoder. New values are accepted through a ready/load handshake and committed only at a frame boundary, so a partially updated number is never displayed.

## Interface
- PRESCALE, 50000, clock cycles each digit is held selected; legal range 2..2^20.
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  request to stage `value`; accepted only on a cycle with ready=1.
- value  in  16  four BCD nibbles; [3:0] = digit 0 (rightmost), [15:12] = digit 3.
- ready  out  1  high when no staged value is pending.
- data_out  out  4  BCD code of the currently selected digit (decoder data input).
- dig_out  out  4  active-low one-cold anode select; bit n low selects digit n.
- frame_tick  out  1  one-cycle pulse during the first cycle of each frame.

## Operation
- Registers: prescale counter cnt (0..PRESCALE-1), digit index idx (0..3), pending[15:0] plus pend_valid, shadow[15:0] (displayed value).
- Reset values: cnt=0, idx=0, shadow=0, pend_valid=0, ready=1, data_out=0, dig_out=4'b1110, frame_tick=0.
- cnt increments every cycle; at PRESCALE-1 it wraps to 0 and idx advances modulo 4 (0→1→2→3→0).
- data_out = shadow nibble [4*idx+3 : 4*idx]; dig_out = ~(1<<idx). Both are registered and computed from next-state idx/shadow, so they change on the same edge as idx.
- Handshake: load && ready captures value into pending, sets pend_valid, and ready drops the next cycle. load while ready=0 is ignored; pending is never overwritten.
- Commit: on the edge where cnt==PRESCALE-1 and idx==3 (frame wrap), if pend_valid then shadow<=pending, pend_valid<=0, ready<=1. data_out shows the new digit 0 on that same edge.
- Same-edge frame wrap and load with ready=1: no pending existed, so nothing commits; the new load becomes pending and commits at the next frame wrap.
- Nibbles >9 are passed through unchanged; the decoder blanks them.
- No state machine beyond the cnt/idx scan counters; every digit is held exactly PRESCALE cycles, a frame is 4*PRESCALE cycles.

## Timing
- dig_out/data_out: constant for PRESCALE cycles per digit; transitions are glitch-free (one register edge).
- Load-to-display latency: from 1 cycle (load accepted on the cycle before the wrap edge) up to 4*PRESCALE cycles.
- ready returns to 1 on the commit edge; the earliest next accepted load is the following cycle.
- frame_tick is registered: high for exactly the first cycle after the frame wrap edge, once per 4*PRESCALE cycles. It is not asserted in the first frame after reset.
- Reset asserted mid-frame or mid-handshake immediately forces all reset values; the pending value is discarded. Scanning restarts at digit 0 on the first edge after deassertion.

## Configuration
- LEAD_BLANK_EN defined: leading-zero blanking is applied. Digits 3..1 that are 0 and have only zero digits to their left output data_out=4'hF (blank code). Digit 0 is never blanked. The anode select still scans normally.
- LEAD_BLANK_EN undefined: all four digits output their BCD nibble unchanged. Zero is shown as 0000.

## Test plan
All scenarios use PRESCALE=4.
- Reset, then run 16 cycles with no load: dig_out sequence is 1110,1101,1011,0111, each held 4 cycles; data_out=0 throughout; frame_tick pulses at cycle 17.
- Load value=16'h1234 mid-frame: ready drops; display keeps the old value until the frame wrap. The next frame shows data_out 4,3,2,1 for digits 0..3, and ready=1 again.
- Second load 16'h9999 while ready=0: it is ignored, and the committed value remains 16'h1234.
- Load with ready=1 on the same cycle as the wrap edge: the value commits one full frame later, not immediately.
- Assert rst during digit 2 with a pending value: outputs return to dig_out=1110, data_out=0, ready=1; the pending value never appears.
- With LEAD_BLANK_EN, value=16'h0070: digits 3 and 2 show F, digit 1 shows 7, and digit 0 shows 0. With value=0, only digit 0 shows 0. Without the macro, the same stimulus shows 0,0,7,0.
